// File: rtl/mmio_responder.sv
`default_nettype none
// ============================================================================
// Module   : mmio_responder
// Purpose  : Memory-mapped I/O target on the CPU data-memory port. Decodes a
//            16-word window and serves switches, buttons (level and sticky
//            rising-edge flags), an LED register and a prescaled down-counting
//            timer with one-shot or auto-reload expiry.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_responder #(
   parameter logic [15:0] IO_BASE  = 16'hFF00,
   parameter int          N_SW     = 10,
   parameter int          N_BTN    = 4,
   parameter int          N_LED    = 10,
   parameter int          PRESCALE = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [15:0]      addr,
   input  logic             wr_en,
   input  logic [15:0]      wr_data,
   output logic [15:0]      rd_data,
   output logic             io_hit,
   input  logic [N_SW-1:0]  sw,
   input  logic [N_BTN-1:0] btn,
   output logic [N_LED-1:0] led,
   output logic             timer_irq
);

   // Word offsets inside the I/O window
   localparam logic [3:0] REG_SW      = 4'h0;
   localparam logic [3:0] REG_BTN     = 4'h1;
   localparam logic [3:0] REG_BTN_EVT = 4'h2;
   localparam logic [3:0] REG_LED     = 4'h3;
   localparam logic [3:0] REG_TCTRL   = 4'h4;
   localparam logic [3:0] REG_TLOAD   = 4'h5;
   localparam logic [3:0] REG_TCOUNT  = 4'h6;
   localparam logic [3:0] REG_TSTAT   = 4'h7;

   localparam int               PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
   localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

   typedef enum logic [0:0] {
      T_IDLE = 1'b0,
      T_RUN  = 1'b1
   } timer_state_t;

   // Synchronizers and button history
   logic [N_SW-1:0]  r_sw_s1, r_sw_s2;
   logic [N_BTN-1:0] r_btn_s1, r_btn_s2, r_btn_prev;
   logic [N_BTN-1:0] r_btn_evt;

   // Timer state
   timer_state_t     r_state;
   logic             r_auto;
   logic [15:0]      r_tload;
   logic [15:0]      r_tcount;
   logic             r_exp;
   logic [PRE_W-1:0] r_presc;

   // Decode
   logic             w_hit;
   logic             w_wr;
   logic             w_wr_btn_evt, w_wr_led, w_wr_tctrl, w_wr_tload, w_wr_tstat;
   logic [N_BTN-1:0] w_btn_rise;
   logic             w_tick;
   logic             w_expire;
   logic [15:0]      w_rd_mux;

   assign w_hit        = (addr[15:4] == IO_BASE[15:4]);
   assign w_wr         = wr_en & w_hit;
   assign w_wr_btn_evt = w_wr && (addr[3:0] == REG_BTN_EVT);
   assign w_wr_led     = w_wr && (addr[3:0] == REG_LED);
   assign w_wr_tctrl   = w_wr && (addr[3:0] == REG_TCTRL);
   assign w_wr_tload   = w_wr && (addr[3:0] == REG_TLOAD);
   assign w_wr_tstat   = w_wr && (addr[3:0] == REG_TSTAT);

   assign w_btn_rise   = r_btn_s2 & ~r_btn_prev;

   // A TCTRL/TLOAD write restarts the prescaler, so a tick landing on the
   // same edge is swallowed rather than acting on stale timer settings.
   assign w_tick   = (r_state == T_RUN) && (r_presc == PRE_MAX) && !w_wr_tctrl && !w_wr_tload;
   assign w_expire = w_tick && (r_tcount <= 16'd1);

   assign timer_irq = r_exp;

   // Two-flop synchronizers for the asynchronous board inputs, plus one more
   // button stage for edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sw_s1    <= '0;
         r_sw_s2    <= '0;
         r_btn_s1   <= '0;
         r_btn_s2   <= '0;
         r_btn_prev <= '0;
      end else begin
         r_sw_s1    <= sw;
         r_sw_s2    <= r_sw_s1;
         r_btn_s1   <= btn;
         r_btn_s2   <= r_btn_s1;
         r_btn_prev <= r_btn_s2;
      end
   end

   // Sticky button-event flags: new rising edges override a simultaneous clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_btn_evt <= '0;
      end else begin
         r_btn_evt <= (r_btn_evt & ~(w_wr_btn_evt ? wr_data[N_BTN-1:0] : '0)) | w_btn_rise;
      end
   end

   // LED register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         led <= '0;
      end else if (w_wr_led) begin
         led <= wr_data[N_LED-1:0];
      end
   end

   // Prescaler: free-runs 0..PRESCALE-1 only while the timer is running
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_presc <= '0;
      end else if ((r_state != T_RUN) || w_wr_tctrl || w_wr_tload || (r_presc == PRE_MAX)) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + PRE_ONE;
      end
   end

   // Timer FSM: register writes, tick-driven countdown, reload/stop on expiry
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= T_IDLE;
         r_auto   <= 1'b0;
         r_tload  <= '0;
         r_tcount <= '0;
         r_exp    <= 1'b0;
      end else begin
         if (w_wr_tload) begin
            r_tload  <= wr_data;
            r_tcount <= wr_data;
         end
         if (w_wr_tctrl) begin
            r_auto  <= wr_data[1];
            r_state <= wr_data[0] ? T_RUN : T_IDLE;
         end else begin
            case (r_state)
               T_IDLE: begin
                  // counter frozen
               end
               T_RUN: begin
                  if (w_tick) begin
                     if (r_tcount > 16'd1) begin
                        r_tcount <= r_tcount - 16'd1;
                     end else if (r_auto) begin
                        r_tcount <= r_tload;
                     end else begin
                        r_tcount <= '0;
                        r_state  <= T_IDLE;
                     end
                  end
               end
               default: r_state <= T_IDLE;
            endcase
         end
         // Expiry beats a simultaneous write-1-to-clear
         if (w_expire) begin
            r_exp <= 1'b1;
         end else if (w_wr_tstat && wr_data[0]) begin
            r_exp <= 1'b0;
         end
      end
   end

   // Read multiplexer over pre-write register values
   always_comb begin
      w_rd_mux = '0;
      case (addr[3:0])
         REG_SW:      w_rd_mux[N_SW-1:0]  = r_sw_s2;
         REG_BTN:     w_rd_mux[N_BTN-1:0] = r_btn_s2;
         REG_BTN_EVT: w_rd_mux[N_BTN-1:0] = r_btn_evt;
         REG_LED:     w_rd_mux[N_LED-1:0] = led;
         REG_TCTRL:   w_rd_mux[1:0]       = {r_auto, (r_state == T_RUN)};
         REG_TLOAD:   w_rd_mux            = r_tload;
         REG_TCOUNT:  w_rd_mux            = r_tcount;
         REG_TSTAT:   w_rd_mux[0]         = r_exp;
         default:     w_rd_mux            = '0;
      endcase
   end

   // Registered read data and hit flag, one cycle after the address
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_data <= '0;
         io_hit  <= 1'b0;
      end else begin
         rd_data <= w_hit ? w_rd_mux : 16'h0000;
         io_hit  <= w_hit;
      end
   end

endmodule
`default_nettype wire
